// File: rtl/adder_seq_ctrl.sv
// Sequencing controller: sums NOPS operands through one shared SUMW-bit adder.
// Optional ADD_SEQ_SAT_EN macro: saturate the accumulator on carry-out instead of wrapping.
module adder_seq_ctrl #(
  parameter int OPW  = 4,
  parameter int NOPS = 5,
  parameter int SUMW = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [OPW-1:0]  in_data,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SUMW-1:0] sum,
  output logic            ovf,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid never drops until the
  // transfer completes.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SUMW-1:0] acc;
  logic [3:0]      cnt;
  logic            ovf_q;
  logic [SUMW:0]   add_full;
  logic            carry;
  logic            beat;
  logic            last_beat;

  // Single shared adder; bit SUMW is the carry-out.
  assign add_full  = {1'b0, acc} + {{(SUMW + 1 - OPW){1'b0}}, in_data};
  assign carry     = add_full[SUMW];
  assign beat      = in_valid && (state == S_ACC);
  assign last_beat = beat && (cnt == 4'(NOPS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_ACC;
      S_ACC:   if (last_beat) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        acc   <= '0;
        cnt   <= '0;
        ovf_q <= 1'b0;
      end else if (beat) begin
        cnt <= cnt + 4'd1;
        if (carry) ovf_q <= 1'b1;
`ifdef ADD_SEQ_SAT_EN
        // Once saturated, any further nonzero operand carries again, so acc stays pinned.
        acc <= carry ? {SUMW{1'b1}} : add_full[SUMW-1:0];
`else
        acc <= add_full[SUMW-1:0];
`endif
      end
    end
  end

  // Every output comes from registers or a state decode only.
  assign in_ready  = (state == S_ACC);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign sum       = acc;
  assign ovf       = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: a default-width instance and a SUMW=5 instance share stimulus;
// a burst table plus directed stall, backpressure, reset and ignored-input sequences.
module tb_adder_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       in_ready,  out_valid,  ovf,  busy;
  logic [6:0] sum;
  logic [1:0] dbg_state;
  logic       in_ready5, out_valid5, ovf5, busy5;
  logic [4:0] sum5;
  logic [1:0] dbg_state5;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [4:0][3:0] ops;
    int              exp_sum;
    logic            exp_ovf;
    int              exp_sum5;
    logic            exp_ovf5;
  } vec_t;

  vec_t vecs[5];

  adder_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .ovf(ovf), .busy(busy), .dbg_state(dbg_state)
  );

  adder_seq_ctrl #(.OPW(4), .NOPS(5), .SUMW(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready5), .out_valid(out_valid5), .out_ready(out_ready), .sum(sum5),
    .ovf(ovf5), .busy(busy5), .dbg_state(dbg_state5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input logic [3:0] a, b, c, d, e, input int s, input logic o,
                              input int s5, input logic o5);
    vec_t v;
    v.ops      = {e, d, c, b, a};
    v.exp_sum  = s;
    v.exp_ovf  = o;
    v.exp_sum5 = s5;
    v.exp_ovf5 = o5;
    return v;
  endfunction

  // Called at a negedge while IDLE; returns at the negedge after the state enters ACC.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("in_ready_after_start", in_ready, 1);
    check("sum_cleared_on_start", sum, 0);
  endtask

  // Feeds five back-to-back beats; out_valid must stay low until the edge after the fifth.
  task automatic feed(input logic [4:0][3:0] ops);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      check("no_early_out_valid", out_valid, 0);
      check("busy_during_acc", busy, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("out_valid_latency", out_valid, 1);
    check("in_ready_low_in_done", in_ready, 0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drops", out_valid, 0);
    check("idle_after_accept", busy, 0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0] = mk(1, 2, 3, 4, 5, 15, 0, 15, 0);
`ifdef ADD_SEQ_SAT_EN
    vecs[1] = mk(15, 15, 15, 1, 1, 47, 0, 31, 1);
    vecs[4] = mk(15, 15, 15, 15, 15, 75, 0, 31, 1);
`else
    vecs[1] = mk(15, 15, 15, 1, 1, 47, 0, 15, 1);
    vecs[4] = mk(15, 15, 15, 15, 15, 75, 0, 11, 1);
`endif
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(6, 9, 10, 0, 3, 28, 0, 28, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven bursts, no stalls, immediate accept
    foreach (vecs[k]) begin
      do_start();
      feed(vecs[k].ops);
      check($sformatf("vec%0d_sum", k), sum, vecs[k].exp_sum);
      check($sformatf("vec%0d_ovf", k), ovf, vecs[k].exp_ovf);
      check($sformatf("vec%0d_sum5", k), sum5, vecs[k].exp_sum5);
      check($sformatf("vec%0d_ovf5", k), ovf5, vecs[k].exp_ovf5);
      accept();
      check($sformatf("vec%0d_sum_kept_idle", k), sum, vecs[k].exp_sum);
    end

    // Backpressure: result held for 3 cycles, in_valid ignored while in DONE
    do_start();
    feed(vecs[4].ops);
    in_valid = 1'b1;
    in_data  = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_sum_stable", sum, 75);
      check("bp_out_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    accept();

    // Stall: 7, two idle cycles, then 8,1,2,3
    do_start();
    in_valid = 1'b1;
    in_data  = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_acc_held", sum, 7);
      check("stall_in_ready", in_ready, 1);
      check("stall_no_out_valid", out_valid, 0);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 4'd8 : 4'(i);
      check("stall_no_early_done", out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stall_done", out_valid, 1);
    check("stall_sum", sum, 21);
    accept();

    // Reset after the 3rd beat, then a fresh burst
    do_start();
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_state", dbg_state, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 0);
    check("midrst_ovf", ovf, 0);
    @(negedge clk);
    check("midrst_no_out_valid", out_valid, 0);
    do_start();
    feed({4'd2, 4'd2, 4'd2, 4'd2, 4'd2});
    check("post_rst_sum", sum, 10);
    accept();

    // start pulsed during ACC and DONE; start in the accept cycle is not seen
    do_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd3;
      start    = (i == 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b1;
    check("start_ignored_sum", sum, 15);
    check("start_ignored_done", out_valid, 1);
    @(negedge clk);
    check("start_ignored_in_done", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("start_not_seen_on_accept", busy, 0);
    @(negedge clk);
    check("single_result", out_valid, 0);
    check("still_idle", busy, 0);

    // in_valid in IDLE must not be accepted
    in_valid = 1'b1;
    in_data  = 4'd9;
    check("idle_in_ready_low", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_no_busy", busy, 0);
    do_start();
    feed({4'd1, 4'd1, 4'd1, 4'd1, 4'd1});
    check("idle_beat_not_counted", sum, 5);
    accept();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
